mem_arbiter: RTL and testbench

- Two-master arbiter and sequencer for the single-port on-chip RAM.
- Shares the RAM between the CPU port (m0) and a loader/DMA port (m1).
- Issues one memory access at a time: read strobe or byte-masked write.
- Returns read data and a one-cycle ack to the winning master. Sits between the masters and Memory in SOC.

---
 rtl/mem_arbiter_if.sv | 44 ++++
 rtl/mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Master/memory bus bundle for mem_arbiter: two master ports plus the RAM side.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  m0_req;
  logic [ADDR_WIDTH-1:0] m0_addr;
  logic [3:0]            m0_wmask;
  logic [31:0]           m0_wdata;
  logic [31:0]           m0_rdata;
  logic                  m0_ack;

  logic                  m1_req;
  logic [ADDR_WIDTH-1:0] m1_addr;
  logic [3:0]            m1_wmask;
  logic [31:0]           m1_wdata;
  logic [31:0]           m1_rdata;
  logic                  m1_ack;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_rstrb;
  logic [3:0]            mem_wmask;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;

  logic                  busy;

  // Arbiter side
  modport slave (
    input  m0_req, m0_addr, m0_wmask, m0_wdata,
    input  m1_req, m1_addr, m1_wmask, m1_wdata,
    input  mem_rdata,
    output m0_rdata, m0_ack, m1_rdata, m1_ack,
    output mem_addr, mem_rstrb, mem_wmask, mem_wdata, busy
  );

  // Requester / RAM side
  modport master (
    output m0_req, m0_addr, m0_wmask, m0_wdata,
    output m1_req, m1_addr, m1_wmask, m1_wdata,
    output mem_rdata,
    input  m0_rdata, m0_ack, m1_rdata, m1_ack,
    input  mem_addr, mem_rstrb, mem_wmask, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master arbiter/sequencer for the single-port on-chip RAM.
// One access at a time: IDLE (grant) -> ACCESS (strobe to RAM) -> RESP (ack).
// Optional grant/conflict counters are compiled in with MEM_ARB_PERF_EN.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 RESET,
  mem_arbiter_if.slave         bus
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0] m0_grants,
  output logic [CNT_WIDTH-1:0] m1_grants,
  output logic [CNT_WIDTH-1:0] conflict_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  mem_rstrb_q, mem_rstrb_d;
  logic [3:0]            mem_wmask_q, mem_wmask_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  m0_ack_q, m0_ack_d;
  logic                  m1_ack_q, m1_ack_d;
  logic                  busy_q, busy_d;
  logic                  pick;
  logic [3:0]            win_wmask;

`ifdef MEM_ARB_PERF_EN
  logic [CNT_WIDTH-1:0]  m0_grants_q, m0_grants_d;
  logic [CNT_WIDTH-1:0]  m1_grants_q, m1_grants_d;
  logic [CNT_WIDTH-1:0]  conflict_q, conflict_d;
`endif

  // Next-state, grant selection and registered memory command
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_rstrb_d  = 1'b0;
    mem_wmask_d  = 4'b0000;
    m0_ack_d     = 1'b0;
    m1_ack_d     = 1'b0;
    pick         = 1'b0;
    win_wmask    = 4'b0000;
`ifdef MEM_ARB_PERF_EN
    m0_grants_d  = m0_grants_q;
    m1_grants_d  = m1_grants_q;
    conflict_d   = conflict_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          // Contested: favour the master that did not win last time
          pick         = (bus.m0_req && bus.m1_req) ? ~last_grant_q : bus.m1_req;
          win_wmask    = pick ? bus.m1_wmask : bus.m0_wmask;
          last_grant_d = pick;
          mem_addr_d   = pick ? bus.m1_addr  : bus.m0_addr;
          mem_wdata_d  = pick ? bus.m1_wdata : bus.m0_wdata;
          mem_wmask_d  = win_wmask;
          mem_rstrb_d  = (win_wmask == 4'b0000);
          state_d      = ACCESS;
`ifdef MEM_ARB_PERF_EN
          if (pick) m1_grants_d = m1_grants_q + CNT_WIDTH'(1);
          else      m0_grants_d = m0_grants_q + CNT_WIDTH'(1);
          if (bus.m0_req && bus.m1_req) conflict_d = conflict_q + CNT_WIDTH'(1);
`endif
        end
      end
      ACCESS: begin
        m0_ack_d = ~last_grant_q;
        m1_ack_d = last_grant_q;
        state_d  = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      mem_addr_q   <= '0;
      mem_rstrb_q  <= 1'b0;
      mem_wmask_q  <= 4'b0000;
      mem_wdata_q  <= 32'h0;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      busy_q       <= 1'b0;
`ifdef MEM_ARB_PERF_EN
      m0_grants_q  <= '0;
      m1_grants_q  <= '0;
      conflict_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mem_addr_q   <= mem_addr_d;
      mem_rstrb_q  <= mem_rstrb_d;
      mem_wmask_q  <= mem_wmask_d;
      mem_wdata_q  <= mem_wdata_d;
      m0_ack_q     <= m0_ack_d;
      m1_ack_q     <= m1_ack_d;
      busy_q       <= busy_d;
`ifdef MEM_ARB_PERF_EN
      m0_grants_q  <= m0_grants_d;
      m1_grants_q  <= m1_grants_d;
      conflict_q   <= conflict_d;
`endif
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_rstrb = mem_rstrb_q;
  assign bus.mem_wmask = mem_wmask_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.m0_ack    = m0_ack_q;
  assign bus.m1_ack    = m1_ack_q;
  assign bus.busy      = busy_q;

  // Read data passes straight from the RAM, only to the master being acked
  assign bus.m0_rdata  = m0_ack_q ? bus.mem_rdata : 32'h0;
  assign bus.m1_rdata  = m1_ack_q ? bus.mem_rdata : 32'h0;

`ifdef MEM_ARB_PERF_EN
  assign m0_grants    = m0_grants_q;
  assign m1_grants    = m1_grants_q;
  assign conflict_cnt = conflict_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: RAM model plus a transaction-level reference
// (round-robin winner, 3-cycle access, shadow memory contents).
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic RESET;
  logic preload;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_WIDTH(32)) bus ();

`ifdef MEM_ARB_PERF_EN
  logic [31:0] m0_grants, m1_grants, conflict_cnt;
`endif

  mem_arbiter #(.ADDR_WIDTH(32), .CNT_WIDTH(32)) dut (
    .clk   (clk),
    .RESET (RESET),
    .bus   (bus)
`ifdef MEM_ARB_PERF_EN
    ,
    .m0_grants    (m0_grants),
    .m1_grants    (m1_grants),
    .conflict_cnt (conflict_cnt)
`endif
  );

  // RAM: 16 words, read data registered one cycle after the strobe
  logic [31:0] ram [16];
  logic [31:0] seed [16];
  logic [31:0] ram_rdata;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) ram[i] <= seed[i];
    end else begin
      if (bus.mem_rstrb) ram_rdata <= ram[bus.mem_addr[5:2]];
      for (int b = 0; b < 4; b++)
        if (bus.mem_wmask[b]) ram[bus.mem_addr[5:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    end
  end
  assign bus.mem_rdata = ram_rdata;

  // Reference model state
  logic [31:0] shadow [16];
  bit          last;
  int unsigned exp_g0, exp_g1, exp_conf;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
    step();
    step();
    RESET    = 1'b0;
    last     = 1'b1;
    exp_g0   = 0;
    exp_g1   = 0;
    exp_conf = 0;
  endtask

  // One IDLE evaluation; if granted, runs the full access and checks it.
  task automatic access(input bit r0, input bit r1,
                        input logic [31:0] a0, input logic [31:0] a1,
                        input logic [3:0] k0, input logic [3:0] k1,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input bit wiggle, output logic [31:0] rd);
    bit          w;
    logic [31:0] a, d;
    logic [3:0]  k;
    rd = 32'h0;
    bus.m0_req = r0;  bus.m0_addr = a0;  bus.m0_wmask = k0;  bus.m0_wdata = d0;
    bus.m1_req = r1;  bus.m1_addr = a1;  bus.m1_wmask = k1;  bus.m1_wdata = d1;
    if (!(r0 || r1)) begin
      step();
      chk("idle_busy", 32'(bus.busy), 32'd0);
      chk("idle_rstrb", 32'(bus.mem_rstrb), 32'd0);
      chk("idle_acks", {30'd0, bus.m1_ack, bus.m0_ack}, 32'd0);
      return;
    end
    w = (r0 && r1) ? ~last : r1;
    last = w;
    if (r0 && r1) exp_conf++;
    if (w) exp_g1++; else exp_g0++;
    a = w ? a1 : a0;
    d = w ? d1 : d0;
    k = w ? k1 : k0;
    step();
    chk("acc_addr", bus.mem_addr, a);
    chk("acc_rstrb", 32'(bus.mem_rstrb), 32'(k == 4'b0000));
    chk("acc_wmask", 32'(bus.mem_wmask), 32'(k));
    chk("acc_wdata", bus.mem_wdata, d);
    chk("acc_busy", 32'(bus.busy), 32'd1);
    chk("acc_acks", {30'd0, bus.m1_ack, bus.m0_ack}, 32'd0);
    if (wiggle) begin
      bus.m0_addr = a0 ^ 32'h50;  bus.m0_wmask = ~k0;  bus.m0_wdata = ~d0;
      bus.m1_addr = a1 ^ 32'h50;  bus.m1_wmask = ~k1;  bus.m1_wdata = ~d1;
    end
    step();
    chk("resp_acks", {30'd0, bus.m1_ack, bus.m0_ack}, w ? 32'd2 : 32'd1);
    chk("resp_strobes", {27'd0, bus.mem_rstrb, bus.mem_wmask}, 32'd0);
    chk("resp_busy", 32'(bus.busy), 32'd1);
    rd = w ? bus.m1_rdata : bus.m0_rdata;
    chk("resp_loser_rdata", w ? bus.m0_rdata : bus.m1_rdata, 32'h0);
    if (k == 4'b0000) chk("resp_rdata", rd, shadow[a[5:2]]);
    else
      for (int b = 0; b < 4; b++)
        if (k[b]) shadow[a[5:2]][8*b +: 8] = d[8*b +: 8];
    step();
    chk("post_acks", {30'd0, bus.m1_ack, bus.m0_ack}, 32'd0);
    chk("post_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] ra0, ra1, rd0, rd1;
    logic [3:0]  rk0, rk1;

    for (int i = 0; i < 16; i++) seed[i] = $urandom();
    seed[4] = 32'hDEADBEEF;
    seed[8] = 32'h5555_0000;
    for (int i = 0; i < 16; i++) shadow[i] = seed[i];
    bus.m0_addr = 32'h0;  bus.m0_wmask = 4'h0;  bus.m0_wdata = 32'h0;
    bus.m1_addr = 32'h0;  bus.m1_wmask = 4'h0;  bus.m1_wdata = 32'h0;
    preload = 1'b1;
    do_reset();
    preload = 1'b0;

    // Reset state
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_rstrb", 32'(bus.mem_rstrb), 32'd0);
    chk("rst_wmask", 32'(bus.mem_wmask), 32'd0);
    chk("rst_wdata", bus.mem_wdata, 32'h0);
    chk("rst_acks", {30'd0, bus.m1_ack, bus.m0_ack}, 32'd0);

    // m0 read of 0x10
    access(1, 0, 32'h10, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 0, rd);
    chk("m0_read_data", rd, 32'hDEADBEEF);

    // m1 partial write of 0x20 then read back
    access(0, 1, 32'h0, 32'h20, 4'h0, 4'b0011, 32'h0, 32'h1234ABCD, 0, rd);
    access(1, 0, 32'h20, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 0, rd);
    chk("wr_readback_low", {16'h0, rd[15:0]}, 32'h0000ABCD);
    chk("wr_readback_high", {rd[31:16], 16'h0}, 32'h55550000);

    // Contested from reset: m0, m1, m0, m1
    do_reset();
    for (int i = 0; i < 4; i++) begin
      access(1, 1, 32'h4, 32'h8, 4'h0, 4'h0, 32'h0, 32'h0, 0, rd);
      chk("rr_winner_data", rd, (i % 2 == 0) ? shadow[1] : shadow[2]);
    end
    access(1, 0, 32'hC, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 0, rd);
`ifdef MEM_ARB_PERF_EN
    chk("perf_m0_grants", m0_grants, 32'd3);
    chk("perf_m1_grants", m1_grants, 32'd2);
    chk("perf_conflicts", conflict_cnt, 32'd4);
`endif

    // Address change after grant is ignored
    access(1, 0, 32'h10, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 1, rd);
    chk("latched_addr_data", rd, 32'hDEADBEEF);

    // Reset during RESP of an m0 read
    bus.m0_req = 1'b1;  bus.m0_addr = 32'h10;  bus.m0_wmask = 4'h0;
    bus.m1_req = 1'b0;
    step();
    step();
    chk("abort_resp_ack", 32'(bus.m0_ack), 32'd1);
    RESET = 1'b1;
    bus.m0_req = 1'b0;
    step();
    RESET = 1'b0;
    last = 1'b1;  exp_g0 = 0;  exp_g1 = 0;  exp_conf = 0;
    chk("abort_acks", {30'd0, bus.m1_ack, bus.m0_ack}, 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_rstrb", 32'(bus.mem_rstrb), 32'd0);
    access(0, 1, 32'h0, 32'h18, 4'h0, 4'h0, 32'h0, 32'h0, 0, rd);

    // Randomized traffic against the reference model
    for (int i = 0; i < 60; i++) begin
      ra0 = $urandom();  ra0[1:0] = 2'b00;
      ra1 = $urandom();  ra1[1:0] = 2'b00;
      rd0 = $urandom();  rd1 = $urandom();
      rk0 = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      rk1 = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ra0, ra1, rk0, rk1, rd0, rd1, 1'($urandom_range(0, 1)), rd);
    end
`ifdef MEM_ARB_PERF_EN
    chk("rand_m0_grants", m0_grants, 32'(exp_g0));
    chk("rand_m1_grants", m1_grants, 32'(exp_g1));
    chk("rand_conflicts", conflict_cnt, 32'(exp_conf));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
